// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared definitions for the bit-serial subtractor: the FSM
//                state encoding and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Operand / difference width used when the instantiating level does not
    // override it.
    localparam int c_default_width = 8;

    // Controller states: waiting, shifting one bit per cycle, result valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_full_sub.sv
`default_nettype none
// ============================================================================
//  Module      : full_sub
//  Description : Combinational one-bit full subtractor. Produces the
//                difference bit and the borrow into the next bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic w_axb;

    // A borrow is generated when b exceeds a, and propagated when the two
    // operand bits are equal.
    always_comb begin
        w_axb = a ^ b;
        diff  = w_axb ^ bin;
        bout  = (~a & b) | (~w_axb & bin);
    end

endmodule : full_sub
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Bit-serial subtractor. Computes a - b - bin one bit per
//                clock, LSB first, and reports the result with a one-cycle
//                done pulse together with the final borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    state_t           r_state;
    logic             r_armed;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_br_next;
    logic             w_accept;

    // Per-bit arithmetic always works on the current LSB of the shifting
    // operand registers.
    full_sub u_bit (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .diff (w_d),
        .bout (w_br_next)
    );

    // A new operation may begin from IDLE or straight out of DONE, but never
    // on the first edge after reset release (r_armed is still low then).
    always_comb begin
        w_accept = r_armed && start && ((r_state == IDLE) || (r_state == DONE));
    end

    // Controller, operand shifters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Shifting in from the top: after WIDTH shifts the bit
                    // produced in step i has landed at position i.
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    if (r_cnt == c_last) begin
                        r_bout  <= w_br_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = r_busy;
        done = r_done;
        diff = r_diff;
        bout = r_bout;
    end

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub
//  Description : Self-checking bench for serial_sub. An 8-bit instance is
//                compared every cycle against an arithmetic reference model
//                and directed literal expectations; a 4-bit instance is swept
//                over every a, b, bin combination.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the 8-bit instance: a pending arithmetic result
    // released after a fixed number of cycles.
    int         m_left = 0;
    logic       m_armed = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_diff = '0, m_pdiff = '0;
    logic       m_bout = 1'b0, m_pbout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_armed <= 1'b0;
            m_done  <= 1'b0;
            m_diff  <= '0;
            m_bout  <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            m_done  <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_diff <= m_pdiff;
                    m_bout <= m_pbout;
                end
            end else if (start8 && m_armed) begin
                m_left  <= 8;
                m_pdiff <= 8'((int'(a8) - int'(b8) - int'(bin8)) & 255);
                m_pbout <= (int'(a8) < int'(b8) + int'(bin8));
            end
        end
    end

    always @(negedge clk) begin
        chk("busy8", busy8, (m_left != 0));
        chk("done8", done8, m_done);
        if (m_left == 0) begin
            chk("diff8", diff8, m_diff);
            chk("bout8", bout8, m_bout);
        end
    end

    task automatic wait_done8(output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (done8) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout8 actual=no_done required=done");
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb);
        int n;
        launch8(a, b, bin);
        wait_done8(n);
        chk({name, "_lat"}, n, 8);
        chk({name, "_diff"}, diff8, ed);
        chk({name, "_bout"}, bout8, eb);
    endtask

    initial begin
        int n;
        int dcount;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);

        // start held across reset release: first edge must not take it
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("first_edge_ignored", busy8, 0);
        @(posedge clk);
        #1 start8 = 1'b0;
        chk("accept_busy", busy8, 1);
        wait_done8(n);
        chk("r31_lat", n, 8);
        chk("r31_diff", diff8, 8'h02);
        chk("r31_bout", bout8, 0);
        @(posedge clk);
        #1 chk("done_one_cycle", done8, 0);
        @(posedge clk);
        #1;

        op8("r32", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        op8("r33a", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);
        // back-to-back start while in DONE
        op8("r33b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        op8("eq", 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0);
        op8("ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        op8("ffb", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
        @(posedge clk);
        #1;

        // start during RUN is ignored
        launch8(8'h05, 8'h03, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(posedge clk);
        #1 start8 = 1'b0;
        chk("r34_busy", busy8, 1);
        wait_done8(n);
        chk("r34_lat", n, 5);
        chk("r34_diff", diff8, 8'h02);
        chk("r34_bout", bout8, 0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of RUN
        launch8(8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r35_busy", busy8, 0);
        chk("r35_done", done8, 0);
        chk("r35_diff", diff8, 0);
        chk("r35_bout", bout8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done8) dcount++;
        end
        chk("r35_no_done", dcount, 0);

        // exhaustive 4-bit sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int k;
                    bit seen;
                    start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); bin4 = ic[0];
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    k = 0;
                    seen = 1'b0;
                    while (!seen && k < 12) begin
                        @(posedge clk);
                        k++;
                        #1 if (done4) seen = 1'b1;
                    end
                    chk("w4_lat", k, 4);
                    chk("w4_diff", diff4, (ia - ib - ic) & 15);
                    chk("w4_bout", bout4, (ia < ib + ic));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_sub
`default_nettype wire
